seq_pattern_tx: RTL

//   Serial pattern transmitter: accepts a parallel bit pattern over a valid/ready

---
 rtl/seq_pattern_tx_if.sv | 28 ++
 rtl/seq_pattern_tx.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx_if.sv
// Load-side handshake bundle for seq_pattern_tx.
//   load_valid  master -> slave  load_data/load_len are valid
//   load_ready  slave  -> master holding buffer can accept a pattern
//   load_data   master -> slave  pattern, bit 0 transmitted first
//   load_len    master -> slave  pattern length in bits minus 1
interface seq_pattern_tx_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LEN_W = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [LEN_W-1:0] load_len;

  modport master (
    output load_valid,
    output load_data,
    output load_len,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_len,
    output load_ready
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter. Accepts a parallel pattern over a valid/ready handshake into a
// one-entry holding buffer and shifts it out LSB first, one bit per bit_en_i strobe. The
// buffer lets the next frame start with no idle bit; rpt_i replays the last frame when the
// buffer is empty.
//   clk, rst_n    clock and asynchronous active-low reset
//   load_if       handshake bundle (slave side): load_valid/load_ready/load_data/load_len
//   bit_en_i      consume the current bit
//   rpt_i         replay the current frame at frame end if nothing is buffered
//   abort_i       synchronous flush of buffer and shifter
//   sout_o        serial data, forced to 0 when sout_valid_o is low
//   sout_valid_o  sout_o carries a frame bit
//   busy_o        shifter active or buffer occupied
//   done_o        one-cycle pulse after the last bit of a frame is consumed
module seq_pattern_tx #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LEN_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_pattern_tx_if.slave load_if,
  input  logic            bit_en_i,
  input  logic            rpt_i,
  input  logic            abort_i,
  output logic            sout_o,
  output logic            sout_valid_o,
  output logic            busy_o,
  output logic            done_o
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e             state_q, state_d;
  logic               buf_valid_q, buf_valid_d;
  logic [WIDTH-1:0]   buf_data_q, buf_data_d;
  logic [LEN_W-1:0]   buf_len_q, buf_len_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   copy_data_q, copy_data_d;
  logic [LEN_W-1:0]   copy_len_q, copy_len_d;
  logic               done_q, done_d;

  logic load_ready;
  logic transfer;
  logic load_from_buf;

  assign load_ready         = ~buf_valid_q & ~abort_i;
  assign load_if.load_ready = load_ready;
  assign transfer           = load_if.load_valid & load_ready;

  always_comb begin
    state_d       = state_q;
    buf_valid_d   = buf_valid_q;
    buf_data_d    = buf_data_q;
    buf_len_d     = buf_len_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    copy_data_d   = copy_data_q;
    copy_len_d    = copy_len_q;
    done_d        = 1'b0;
    load_from_buf = 1'b0;

    if (abort_i) begin
      // Flush wins over everything; no done pulse for the killed frame.
      state_d     = StIdle;
      buf_valid_d = 1'b0;
      shreg_d     = '0;
      cnt_d       = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (buf_valid_q) load_from_buf = 1'b1;
        end
        StShift: begin
          if (bit_en_i) begin
            if (cnt_q != '0) begin
              shreg_d = shreg_q >> 1;
              cnt_d   = cnt_q - 1'b1;
            end else begin
              done_d = 1'b1;
              if (buf_valid_q) begin
                load_from_buf = 1'b1;
              end else if (rpt_i) begin
                shreg_d = copy_data_q;
                cnt_d   = copy_len_q;
              end else begin
                state_d = StIdle;
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase

      if (load_from_buf) begin
        shreg_d     = buf_data_q;
        cnt_d       = buf_len_q;
        copy_data_d = buf_data_q;
        copy_len_d  = buf_len_q;
        buf_valid_d = 1'b0;
        state_d     = StShift;
      end

      // Applied after the shifter load so a same-edge refill keeps the new pattern.
      if (transfer) begin
        buf_valid_d = 1'b1;
        buf_data_d  = load_if.load_data;
        buf_len_d   = load_if.load_len;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
      buf_len_q   <= '0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      copy_data_q <= '0;
      copy_len_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      buf_len_q   <= buf_len_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      copy_data_q <= copy_data_d;
      copy_len_q  <= copy_len_d;
      done_q      <= done_d;
    end
  end

  assign sout_valid_o = (state_q == StShift);
  assign sout_o       = sout_valid_o & shreg_q[0];
  assign busy_o       = (state_q == StShift) | buf_valid_q;
  assign done_o       = done_q;

endmodule
